// File: rtl/br_resolve_sequencer.sv
// ID-stage sequencer for bez/bnez resolution: it stalls on an unforwarded rB, resolves
// the branch, pulses the PC select, flushes the wrong-path fetch and keeps stall statistics.
module br_resolve_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_STALL  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ID_valid,
    input  logic                  ID_decode_ctrl_bez,
    input  logic                  ID_decode_ctrl_bnez,
    input  logic                  ID_forward_rB,
    input  logic                  fwd_data_valid,
    input  logic [0:DATA_WIDTH-1] M_type_rD_data,
    output logic                  ID_br_ctrl,
    output logic                  br_hazard_stall,
    output logic                  IF_flush,
    output logic                  br_timeout_err,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0]           MAX_STALL_C = 8'(MAX_STALL);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C   = {CNT_WIDTH{1'b1}};

    // bez takes priority over bnez whenever both decode bits are set.
    function automatic logic resolve_taken(input logic is_bez, input logic is_zero);
        return is_bez ? is_zero : ~is_zero;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [7:0]             wait_cnt_r;
    logic [7:0]             wait_cnt_nxt_s;
    logic                   type_bez_r;
    logic                   type_bez_nxt_s;
    logic                   br_timeout_err_r;
    logic [CNT_WIDTH-1:0]   stall_cycles_r;
    logic                   br_s;
    logic                   zero_s;
    logic                   br_ctrl_s;
    logic                   stall_s;
    logic                   flush_s;
    logic                   timeout_set_s;

    assign br_s   = ID_valid & (ID_decode_ctrl_bez | ID_decode_ctrl_bnez);
    assign zero_s = ~|M_type_rD_data;

    // Next-state and Mealy output decode.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        type_bez_nxt_s = type_bez_r;
        br_ctrl_s      = 1'b0;
        stall_s        = 1'b0;
        flush_s        = 1'b0;
        timeout_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (br_s) begin
                    if (ID_forward_rB && !fwd_data_valid) begin
                        stall_s        = 1'b1;
                        state_nxt_s    = ST_WAIT;
                        wait_cnt_nxt_s = 8'd1;
                        type_bez_nxt_s = ID_decode_ctrl_bez;
                    end else if (resolve_taken(ID_decode_ctrl_bez, zero_s)) begin
                        br_ctrl_s   = 1'b1;
                        flush_s     = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // ID is frozen while waiting, so only the captured branch type matters.
                if (fwd_data_valid) begin
                    if (resolve_taken(type_bez_r, zero_s)) begin
                        br_ctrl_s   = 1'b1;
                        flush_s     = 1'b1;
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (wait_cnt_r < MAX_STALL_C) begin
                    stall_s        = 1'b1;
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end else begin
                    timeout_set_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, wait counter and captured branch type.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
            type_bez_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            type_bez_r <= type_bez_nxt_s;
        end
    end

    // Sticky watchdog flag and saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_timeout_err_r <= 1'b0;
            stall_cycles_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            if (timeout_set_s) begin
                br_timeout_err_r <= 1'b1;
            end else begin
                br_timeout_err_r <= br_timeout_err_r;
            end
            if (stall_s && (stall_cycles_r != CNT_MAX_C)) begin
                stall_cycles_r <= stall_cycles_r + CNT_WIDTH'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    // Front-end controls are held low for the whole time reset is asserted.
    assign ID_br_ctrl      = br_ctrl_s & ~reset;
    assign br_hazard_stall = stall_s & ~reset;
    assign IF_flush        = flush_s & ~reset;
    assign br_timeout_err  = br_timeout_err_r;
    assign stall_cycles    = stall_cycles_r;

endmodule

// File: tb/tb_br_resolve_sequencer.sv
// Scoreboard bench for br_resolve_sequencer: expected Mealy outputs are queued per driven
// cycle and compared at the falling edge; registered counters are checked directly.
module tb_br_resolve_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_valid, ID_decode_ctrl_bez, ID_decode_ctrl_bnez, ID_forward_rB, fwd_data_valid;
    logic [0:63] M_type_rD_data;
    logic        ID_br_ctrl, br_hazard_stall, IF_flush, br_timeout_err;
    logic [15:0] stall_cycles;

    typedef struct {
        logic br;
        logic stall;
        logic flush;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] base_cnt;

    br_resolve_sequencer #(.DATA_WIDTH(64), .MAX_STALL(4), .CNT_WIDTH(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .ID_valid           (ID_valid),
        .ID_decode_ctrl_bez (ID_decode_ctrl_bez),
        .ID_decode_ctrl_bnez(ID_decode_ctrl_bnez),
        .ID_forward_rB      (ID_forward_rB),
        .fwd_data_valid     (fwd_data_valid),
        .M_type_rD_data     (M_type_rD_data),
        .ID_br_ctrl         (ID_br_ctrl),
        .br_hazard_stall    (br_hazard_stall),
        .IF_flush           (IF_flush),
        .br_timeout_err     (br_timeout_err),
        .stall_cycles       (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic bz, input logic bnz, input logic fr,
                         input logic fv, input logic [63:0] d);
        ID_valid            = v;
        ID_decode_ctrl_bez  = bz;
        ID_decode_ctrl_bnez = bnz;
        ID_forward_rB       = fr;
        fwd_data_valid      = fv;
        M_type_rD_data      = d;
    endtask

    // One clock of stimulus with the outputs expected during that cycle.
    task automatic step(input logic v, input logic bz, input logic bnz, input logic fr,
                        input logic fv, input logic [63:0] d,
                        input logic eb, input logic es, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v, bz, bnz, fr, fv, d);
        e.br = eb; e.stall = es; e.flush = ef;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ID_br_ctrl", 64'(ID_br_ctrl), 64'(e.br));
            chk("br_hazard_stall", 64'(br_hazard_stall), 64'(e.stall));
            chk("IF_flush", 64'(IF_flush), 64'(e.flush));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        #12;
        chk("rst_br", 64'(ID_br_ctrl), 64'd0);
        chk("rst_flush", 64'(IF_flush), 64'd0);
        chk("rst_stall", 64'(br_hazard_stall), 64'd0);
        chk("rst_err", 64'(br_timeout_err), 64'd0);
        chk("rst_cnt", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        reset = 1'b0;

        // No-hazard taken bez, then the flush bubble.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("cnt_t1", 64'(stall_cycles), 64'd0);

        // Dependent bnez, data 5 after two stall cycles; ID shows bez while waiting.
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0005, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("cnt_t2", 64'(stall_cycles), 64'd2);

        // Dependent bez not taken, followed at once by a no-hazard taken bez.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("cnt_t3", 64'(stall_cycles), 64'd3);

        // Wrong-path branch in FLUSH, bez priority, bnez both ways, same-cycle forward.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("cnt_t6", 64'(stall_cycles), 64'd3);

        // Forward arrives on the MAX_STALL cycle: normal resolve, no error.
        base_cnt = stall_cycles;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("err_edge", 64'(br_timeout_err), 64'd0);
        chk("cnt_edge", 64'(stall_cycles), 64'(base_cnt + 16'd4));

        // Forward never arrives: four stalls then fall-through with sticky error.
        base_cnt = stall_cycles;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        chk("err_set", 64'(br_timeout_err), 64'd1);
        chk("cnt_wdog", 64'(stall_cycles), 64'(base_cnt + 16'd4));
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'd3, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("err_sticky", 64'(br_timeout_err), 64'd1);

        // Asynchronous reset during the second WAIT cycle.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_br", 64'(ID_br_ctrl), 64'd0);
        chk("arst_stall", 64'(br_hazard_stall), 64'd0);
        chk("arst_flush", 64'(IF_flush), 64'd0);
        chk("arst_err", 64'(br_timeout_err), 64'd0);
        chk("arst_cnt", 64'(stall_cycles), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("post_cnt", 64'(stall_cycles), 64'd0);

        @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/br_resolve_sequencer.md
Name: br_resolve_sequencer

Overview:
- Sequences conditional-branch resolution (bez/bnez) in the ID stage of the core.
- When the branch operand rB depends on an in-flight producer, holds the front end until the forwarded value arrives.
- Then resolves the branch, drives the PC-select pulse, and squashes the wrong-path fetch for one cycle.
- Adds a stall watchdog and a stall-cycle counter for the performance/debug registers.

Parameters:
- DATA_WIDTH, 64, width of forwarded operand; bus indexed [0:DATA_WIDTH-1].
- MAX_STALL, 4, max cycles spent in WAIT before watchdog abort (range 1..255).
- CNT_WIDTH, 16, width of saturating stall-cycle counter.

Ports:
- clk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ID_valid  in  1  valid instruction present in ID.
- ID_decode_ctrl_bez  in  1  decoded branch-if-zero.
- ID_decode_ctrl_bnez  in  1  decoded branch-if-nonzero.
- ID_forward_rB  in  1  rB produced by an in-flight instruction, not yet forwardable.
- fwd_data_valid  in  1  producer result present on M_type_rD_data this cycle.
- M_type_rD_data  in  DATA_WIDTH  forwarded rB value.
- ID_br_ctrl  out  1  branch taken; 1-cycle pulse to PC mux.
- br_hazard_stall  out  1  hold PC and IF/ID register.
- IF_flush  out  1  squash IF/ID contents; 1-cycle pulse.
- br_timeout_err  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_WIDTH  cycles with br_hazard_stall=1, saturating.

Behaviour:
- Reset: state=IDLE, wait_cnt=0, br_timeout_err=0, stall_cycles=0. ID_br_ctrl, br_hazard_stall and IF_flush are forced to 0 while reset is high. Reset mid-WAIT aborts with no taken pulse.
- br = ID_valid & (bez | bnez). If bez and bnez are both high, bez wins.
- Evaluation: zero = ~|M_type_rD_data; taken = bez ? zero : ~zero.
- Outputs are Mealy (combinational from state + inputs). State, counters and flags are registered.
- IDLE:
  - No br: all outputs 0.
  - br & ID_forward_rB & ~fwd_data_valid: stall=1; next=WAIT; wait_cnt<=1.
  - br & (~ID_forward_rB | fwd_data_valid): resolve same cycle, stall=0.
    - Taken: ID_br_ctrl=1, IF_flush=1, next=FLUSH.
    - Not taken: stay IDLE.
- WAIT: ID inputs are ignored (ID is held); the bez/bnez type captured on WAIT entry is used.
  - fwd_data_valid: resolve with the captured type; stall=0; taken -> pulses, next=FLUSH; else next=IDLE.
  - ~fwd_data_valid & wait_cnt<MAX_STALL: stall=1; wait_cnt++.
  - ~fwd_data_valid & wait_cnt==MAX_STALL: stall=0; no taken pulse (fall-through); br_timeout_err<=1; next=IDLE.
  - fwd_data_valid on the MAX_STALL cycle resolves normally, no error.
- FLUSH: one cycle; all outputs 0; ID contents are the squashed instruction and are ignored even if they decode as a branch; next=IDLE.
- Back-to-back: a branch in ID in the cycle after a not-taken resolve is evaluated normally from IDLE.
- Latency:
  - No-dependency branch resolves in 0 extra cycles.
  - Dependent branch resolves in the cycle fwd_data_valid rises.
  - Taken always costs exactly 1 bubble (FLUSH).
- stall_cycles: increments every cycle br_hazard_stall=1; holds at all-ones.
- br_timeout_err: cleared only by reset.

Test Plan:
- No hazard, bez=1, M_type_rD_data=0, ID_forward_rB=0 -> same cycle ID_br_ctrl=1, IF_flush=1, stall=0; next cycle FLUSH with all outputs 0; stall_cycles=0.
- bnez=1, ID_forward_rB=1, fwd_data_valid low 2 cycles then high with data=0x0000_0000_0000_0005 -> stall=1 for 2 cycles; third cycle ID_br_ctrl=1, IF_flush=1, stall=0; stall_cycles=2.
- bez=1, dependency, data arrives after 1 cycle =0x1 -> 1 stall cycle, then not taken (ID_br_ctrl=0, IF_flush=0), back in IDLE; immediately following no-hazard bez with data=0 is taken.
- MAX_STALL=4, dependency, fwd_data_valid never rises -> stall=1 for 4 cycles, 5th cycle stall=0, no taken pulse, br_timeout_err=1 and stays 1 after further branches; stall_cycles=4.
- Reset asserted asynchronously in the 2nd WAIT cycle -> all outputs 0 immediately; after release, state IDLE, counters 0, no spurious ID_br_ctrl.
- Taken branch followed next cycle by ID_valid=1, bez=1, data=0 (wrong-path instruction) -> FLUSH ignores it, ID_br_ctrl=0; bez=bnez=1 with data=0 in IDLE -> taken (bez priority).
